// File: rtl/packet_processor_receiver.sv
// Ingress stage of the packet processor: classifies each packet on its first beat and steers it to the
// processed or bypass output, each through a one-beat register slice. Optional counters: PACKET_RECEIVER_STATS_EN.
module packet_processor_receiver #(
  parameter int          TDATA_WIDTH     = 256,
  parameter int          TUSER_WIDTH     = 128,
  parameter logic [15:0] MATCH_ETHERTYPE = 16'h0800,
  localparam int         TKEEP_WIDTH     = TDATA_WIDTH / 8
) (
  input  logic                   axis_aclk,
  input  logic                   axis_resetn,
  input  logic                   processing_enable,
  input  logic [TDATA_WIDTH-1:0] packet_in_axis_tdata,
  input  logic [TKEEP_WIDTH-1:0] packet_in_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0] packet_in_axis_tuser,
  input  logic                   packet_in_axis_tvalid,
  output logic                   packet_in_axis_tready,
  input  logic                   packet_in_axis_tlast,
  output logic [TDATA_WIDTH-1:0] processed_packet_out_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] processed_packet_out_axis_tkeep,
  output logic [TUSER_WIDTH-1:0] processed_packet_out_axis_tuser,
  output logic                   processed_packet_out_axis_tvalid,
  output logic                   processed_packet_out_axis_tlast,
  input  logic                   processed_packet_out_axis_tready,
  output logic [TDATA_WIDTH-1:0] packet_to_bypass_out_axis_tdata,
  output logic [TKEEP_WIDTH-1:0] packet_to_bypass_out_axis_tkeep,
  output logic [TUSER_WIDTH-1:0] packet_to_bypass_out_axis_tuser,
  output logic                   packet_to_bypass_out_axis_tvalid,
  output logic                   packet_to_bypass_out_axis_tlast,
`ifdef PACKET_RECEIVER_STATS_EN
  input  logic                   packet_to_bypass_out_axis_tready,
  output logic [31:0]            proc_pkt_count,
  output logic [31:0]            bypass_pkt_count
`else
  input  logic                   packet_to_bypass_out_axis_tready
`endif
);

  typedef enum logic [1:0] {ST_SOP, ST_FWD_PROC, ST_FWD_BYP} state_e;

  state_e                 state_q, state_d;
  logic [TDATA_WIDTH-1:0] proc_tdata_q, proc_tdata_d, byp_tdata_q, byp_tdata_d;
  logic [TKEEP_WIDTH-1:0] proc_tkeep_q, proc_tkeep_d, byp_tkeep_q, byp_tkeep_d;
  logic [TUSER_WIDTH-1:0] proc_tuser_q, proc_tuser_d, byp_tuser_q, byp_tuser_d;
  logic                   proc_tvalid_q, proc_tvalid_d, byp_tvalid_q, byp_tvalid_d;
  logic                   proc_tlast_q, proc_tlast_d, byp_tlast_q, byp_tlast_d;

  logic [15:0] ethertype;
  logic        cls_proc, sel_proc, proc_slot_ready, byp_slot_ready, accept;

  always_comb begin
    ethertype       = {packet_in_axis_tdata[103:96], packet_in_axis_tdata[111:104]};
    cls_proc        = processing_enable && packet_in_axis_tkeep[13] && (ethertype == MATCH_ETHERTYPE);
    sel_proc        = (state_q == ST_SOP) ? cls_proc : (state_q == ST_FWD_PROC);
    proc_slot_ready = !proc_tvalid_q || processed_packet_out_axis_tready;
    byp_slot_ready  = !byp_tvalid_q || packet_to_bypass_out_axis_tready;
    // Holding tready low during reset keeps upstream from handing over beats that would be lost.
    packet_in_axis_tready = axis_resetn && (sel_proc ? proc_slot_ready : byp_slot_ready);
    accept = packet_in_axis_tvalid && packet_in_axis_tready;

    state_d = state_q;
    if (accept) begin
      if (packet_in_axis_tlast)  state_d = ST_SOP;
      else if (state_q == ST_SOP) state_d = cls_proc ? ST_FWD_PROC : ST_FWD_BYP;
    end

    proc_tdata_d  = proc_tdata_q;
    proc_tkeep_d  = proc_tkeep_q;
    proc_tuser_d  = proc_tuser_q;
    proc_tlast_d  = proc_tlast_q;
    proc_tvalid_d = proc_tvalid_q;
    if (accept && sel_proc) begin
      proc_tdata_d  = packet_in_axis_tdata;
      proc_tkeep_d  = packet_in_axis_tkeep;
      proc_tuser_d  = packet_in_axis_tuser;
      proc_tlast_d  = packet_in_axis_tlast;
      proc_tvalid_d = 1'b1;
    end else if (processed_packet_out_axis_tready) begin
      proc_tvalid_d = 1'b0;
    end

    byp_tdata_d  = byp_tdata_q;
    byp_tkeep_d  = byp_tkeep_q;
    byp_tuser_d  = byp_tuser_q;
    byp_tlast_d  = byp_tlast_q;
    byp_tvalid_d = byp_tvalid_q;
    if (accept && !sel_proc) begin
      byp_tdata_d  = packet_in_axis_tdata;
      byp_tkeep_d  = packet_in_axis_tkeep;
      byp_tuser_d  = packet_in_axis_tuser;
      byp_tlast_d  = packet_in_axis_tlast;
      byp_tvalid_d = 1'b1;
    end else if (packet_to_bypass_out_axis_tready) begin
      byp_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q       <= ST_SOP;
      proc_tdata_q  <= '0;
      proc_tkeep_q  <= '0;
      proc_tuser_q  <= '0;
      proc_tlast_q  <= 1'b0;
      proc_tvalid_q <= 1'b0;
      byp_tdata_q   <= '0;
      byp_tkeep_q   <= '0;
      byp_tuser_q   <= '0;
      byp_tlast_q   <= 1'b0;
      byp_tvalid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      proc_tdata_q  <= proc_tdata_d;
      proc_tkeep_q  <= proc_tkeep_d;
      proc_tuser_q  <= proc_tuser_d;
      proc_tlast_q  <= proc_tlast_d;
      proc_tvalid_q <= proc_tvalid_d;
      byp_tdata_q   <= byp_tdata_d;
      byp_tkeep_q   <= byp_tkeep_d;
      byp_tuser_q   <= byp_tuser_d;
      byp_tlast_q   <= byp_tlast_d;
      byp_tvalid_q  <= byp_tvalid_d;
    end
  end

  assign processed_packet_out_axis_tdata  = proc_tdata_q;
  assign processed_packet_out_axis_tkeep  = proc_tkeep_q;
  assign processed_packet_out_axis_tuser  = proc_tuser_q;
  assign processed_packet_out_axis_tlast  = proc_tlast_q;
  assign processed_packet_out_axis_tvalid = proc_tvalid_q;
  assign packet_to_bypass_out_axis_tdata  = byp_tdata_q;
  assign packet_to_bypass_out_axis_tkeep  = byp_tkeep_q;
  assign packet_to_bypass_out_axis_tuser  = byp_tuser_q;
  assign packet_to_bypass_out_axis_tlast  = byp_tlast_q;
  assign packet_to_bypass_out_axis_tvalid = byp_tvalid_q;

`ifdef PACKET_RECEIVER_STATS_EN
  logic [31:0] proc_pkt_count_q, proc_pkt_count_d, bypass_pkt_count_q, bypass_pkt_count_d;
  logic        sop_accept;

  always_comb begin
    sop_accept         = accept && (state_q == ST_SOP);
    proc_pkt_count_d   = proc_pkt_count_q;
    bypass_pkt_count_d = bypass_pkt_count_q;
    if (sop_accept && cls_proc)  proc_pkt_count_d   = proc_pkt_count_q + 32'd1;
    if (sop_accept && !cls_proc) bypass_pkt_count_d = bypass_pkt_count_q + 32'd1;
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      proc_pkt_count_q   <= '0;
      bypass_pkt_count_q <= '0;
    end else begin
      proc_pkt_count_q   <= proc_pkt_count_d;
      bypass_pkt_count_q <= bypass_pkt_count_d;
    end
  end

  assign proc_pkt_count   = proc_pkt_count_q;
  assign bypass_pkt_count = bypass_pkt_count_q;
`endif

endmodule

// File: tb/tb_packet_processor_receiver.sv
// Directed bench for packet_processor_receiver; stats checks run when PACKET_RECEIVER_STATS_EN is defined.
module tb_packet_processor_receiver;

  logic         clk, rst_n, en;
  logic [255:0] in_data;
  logic [31:0]  in_keep;
  logic [127:0] in_user;
  logic         in_valid, in_ready, in_last;
  logic [255:0] proc_data, byp_data;
  logic [31:0]  proc_keep, byp_keep;
  logic [127:0] proc_user, byp_user;
  logic         proc_valid, proc_last, proc_rdy;
  logic         byp_valid, byp_last, byp_rdy;
`ifdef PACKET_RECEIVER_STATS_EN
  logic [31:0]  proc_cnt, byp_cnt;
`endif

  int total = 0;
  int bad   = 0;

  packet_processor_receiver dut (
    .axis_aclk                        (clk),
    .axis_resetn                      (rst_n),
    .processing_enable                (en),
    .packet_in_axis_tdata             (in_data),
    .packet_in_axis_tkeep             (in_keep),
    .packet_in_axis_tuser             (in_user),
    .packet_in_axis_tvalid            (in_valid),
    .packet_in_axis_tready            (in_ready),
    .packet_in_axis_tlast             (in_last),
    .processed_packet_out_axis_tdata  (proc_data),
    .processed_packet_out_axis_tkeep  (proc_keep),
    .processed_packet_out_axis_tuser  (proc_user),
    .processed_packet_out_axis_tvalid (proc_valid),
    .processed_packet_out_axis_tlast  (proc_last),
    .processed_packet_out_axis_tready (proc_rdy),
    .packet_to_bypass_out_axis_tdata  (byp_data),
    .packet_to_bypass_out_axis_tkeep  (byp_keep),
    .packet_to_bypass_out_axis_tuser  (byp_user),
    .packet_to_bypass_out_axis_tvalid (byp_valid),
    .packet_to_bypass_out_axis_tlast  (byp_last),
`ifdef PACKET_RECEIVER_STATS_EN
    .packet_to_bypass_out_axis_tready (byp_rdy),
    .proc_pkt_count                   (proc_cnt),
    .bypass_pkt_count                 (byp_cnt)
`else
    .packet_to_bypass_out_axis_tready (byp_rdy)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Beat payload: every byte carries the tag, except bytes 12/13 which hold the EtherType (MSB first).
  function automatic logic [255:0] mk(input logic [15:0] eth, input logic [7:0] tag);
    logic [255:0] d;
    d = {32{tag}};
    d[111:96] = {eth[7:0], eth[15:8]};
    return d;
  endfunction

  task automatic applyStimulus(input logic [255:0] data, input logic [31:0] keep, input logic last);
    in_data  = data;
    in_keep  = keep;
    in_user  = {16{data[7:0]}};
    in_last  = last;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; proc_rdy = 1'b1; byp_rdy = 1'b1;
    in_data = '0; in_keep = '0; in_user = '0; in_valid = 1'b0; in_last = 1'b0;
    #3;
    checkOutput("rst_tready", in_ready, 0);
    checkOutput("rst_proc_valid", proc_valid, 0);
    checkOutput("rst_byp_valid", byp_valid, 0);
    checkOutput("rst_proc_data", proc_data, 0);
    checkOutput("rst_byp_last", byp_last, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // IPv4 packet of three beats onto the processed path
    cycle(); applyStimulus(mk(16'h0800, 8'h11), 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    checkOutput("ip_tready", in_ready, 1);
    checkOutput("ip_pre_valid", proc_valid, 0);
    cycle(); applyStimulus(mk(16'hAAAA, 8'h12), 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    checkOutput("ip_b1_valid", proc_valid, 1);
    checkOutput("ip_b1_data", proc_data, mk(16'h0800, 8'h11));
    checkOutput("ip_b1_byp", byp_valid, 0);
    cycle(); applyStimulus(mk(16'hAAAA, 8'h13), 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    checkOutput("ip_b2_data", proc_data, mk(16'hAAAA, 8'h12));
    checkOutput("ip_b2_last", proc_last, 0);
    cycle(); idle();
    @(negedge clk);
    checkOutput("ip_b3_data", proc_data, mk(16'hAAAA, 8'h13));
    checkOutput("ip_b3_last", proc_last, 1);
    checkOutput("ip_b3_user", proc_user, {16{8'h13}});
    checkOutput("ip_b3_byp", byp_valid, 0);
    cycle();
    @(negedge clk);
    checkOutput("ip_drained", proc_valid, 0);

    // One-beat ARP then back-to-back IPv4
    cycle(); applyStimulus(mk(16'h0806, 8'h21), 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    checkOutput("arp_tready", in_ready, 1);
    cycle(); applyStimulus(mk(16'h0800, 8'h22), 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    checkOutput("arp_valid", byp_valid, 1);
    checkOutput("arp_data", byp_data, mk(16'h0806, 8'h21));
    checkOutput("arp_last", byp_last, 1);
    checkOutput("arp_no_bubble", in_ready, 1);
    checkOutput("arp_proc_idle", proc_valid, 0);
    cycle(); applyStimulus(mk(16'hAAAA, 8'h23), 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    checkOutput("b2b_valid", proc_valid, 1);
    checkOutput("b2b_data", proc_data, mk(16'h0800, 8'h22));
    checkOutput("b2b_byp_clr", byp_valid, 0);
    cycle(); idle();
    @(negedge clk);
    checkOutput("b2b_b2_data", proc_data, mk(16'hAAAA, 8'h23));
    checkOutput("b2b_b2_last", proc_last, 1);

    // Enable off, runt SOP, and enable toggled mid-packet
    cycle(); en = 1'b0; applyStimulus(mk(16'h0800, 8'h31), 32'hFFFFFFFF, 1'b1);
    cycle(); en = 1'b1; applyStimulus(mk(16'h0800, 8'h32), 32'h00000FFF, 1'b1);
    @(negedge clk);
    checkOutput("dis_byp_valid", byp_valid, 1);
    checkOutput("dis_byp_data", byp_data, mk(16'h0800, 8'h31));
    checkOutput("dis_proc_idle", proc_valid, 0);
    cycle(); applyStimulus(mk(16'h0800, 8'h33), 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    checkOutput("runt_byp_data", byp_data, mk(16'h0800, 8'h32));
    checkOutput("runt_byp_keep", byp_keep, 32'h00000FFF);
    cycle(); en = 1'b0; applyStimulus(mk(16'hAAAA, 8'h34), 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    checkOutput("tog_b1_data", proc_data, mk(16'h0800, 8'h33));
    cycle(); applyStimulus(mk(16'hAAAA, 8'h35), 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    checkOutput("tog_b2_data", proc_data, mk(16'hAAAA, 8'h34));
    checkOutput("tog_b2_byp", byp_valid, 0);
    cycle(); en = 1'b1; idle();
    @(negedge clk);
    checkOutput("tog_b3_data", proc_data, mk(16'hAAAA, 8'h35));
    checkOutput("tog_b3_last", proc_last, 1);
    checkOutput("tog_b3_byp", byp_valid, 0);

    // Backpressure on the processed path
    cycle(); proc_rdy = 1'b0; applyStimulus(mk(16'h0800, 8'h41), 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    checkOutput("bp_empty_tready", in_ready, 1);
    cycle(); applyStimulus(mk(16'hAAAA, 8'h42), 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    checkOutput("bp_full_data", proc_data, mk(16'h0800, 8'h41));
    checkOutput("bp_full_tready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      @(negedge clk);
      checkOutput("bp_hold_data", proc_data, mk(16'h0800, 8'h41));
      checkOutput("bp_hold_tready", in_ready, 0);
    end
    cycle(); proc_rdy = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_tready", in_ready, 1);
    checkOutput("bp_release_data", proc_data, mk(16'h0800, 8'h41));
    cycle(); applyStimulus(mk(16'hAAAA, 8'h43), 32'hFFFFFFFF, 1'b0);
    @(negedge clk);
    checkOutput("bp_b2_data", proc_data, mk(16'hAAAA, 8'h42));
    cycle(); applyStimulus(mk(16'hAAAA, 8'h44), 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    checkOutput("bp_b3_data", proc_data, mk(16'hAAAA, 8'h43));
    cycle(); proc_rdy = 1'b0; applyStimulus(mk(16'h0806, 8'h45), 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    checkOutput("bp_b4_data", proc_data, mk(16'hAAAA, 8'h44));
    checkOutput("bp_b4_last", proc_last, 1);
    checkOutput("bp_byp_not_blocked", in_ready, 1);
    cycle(); applyStimulus(mk(16'h0800, 8'h46), 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    checkOutput("bp_byp_data", byp_data, mk(16'h0806, 8'h45));
    checkOutput("bp_byp_valid", byp_valid, 1);
    checkOutput("bp_proc_stalled", proc_data, mk(16'hAAAA, 8'h44));
    checkOutput("bp_sop_held", in_ready, 0);
    cycle(); proc_rdy = 1'b1;
    @(negedge clk);
    checkOutput("bp_sop_free", in_ready, 1);
    checkOutput("bp_byp_drained", byp_valid, 0);
    cycle(); idle();
    @(negedge clk);
    checkOutput("bp_sop_data", proc_data, mk(16'h0800, 8'h46));
    checkOutput("bp_sop_last", proc_last, 1);

    // Reset while the bypass packet is mid-flight
    cycle(); applyStimulus(mk(16'h0806, 8'h51), 32'hFFFFFFFF, 1'b0);
    cycle(); applyStimulus(mk(16'hAAAA, 8'h52), 32'hFFFFFFFF, 1'b0);
    cycle(); idle();
    @(negedge clk);
    checkOutput("mid_byp_data", byp_data, mk(16'hAAAA, 8'h52));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_byp_valid", byp_valid, 0);
    checkOutput("mid_rst_proc_valid", proc_valid, 0);
    checkOutput("mid_rst_tready", in_ready, 0);
    checkOutput("mid_rst_byp_data", byp_data, 0);
    @(negedge clk) rst_n = 1'b1;
    cycle(); applyStimulus(mk(16'h0800, 8'h53), 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    checkOutput("post_rst_tready", in_ready, 1);
    cycle(); idle();
    @(negedge clk);
    checkOutput("post_rst_valid", proc_valid, 1);
    checkOutput("post_rst_data", proc_data, mk(16'h0800, 8'h53));
    checkOutput("post_rst_byp", byp_valid, 0);

`ifdef PACKET_RECEIVER_STATS_EN
    // Counters restarted at the reset above; only the last IPv4 packet has been counted since.
    checkOutput("cnt_after_rst_proc", proc_cnt, 1);
    checkOutput("cnt_after_rst_byp", byp_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(); applyStimulus(mk(16'h0800, 8'(8'h60 + i)), 32'hFFFFFFFF, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(); applyStimulus(mk(16'h0806, 8'(8'h70 + i)), 32'hFFFFFFFF, 1'b1);
    end
    cycle(); idle();
    @(negedge clk);
    checkOutput("cnt_proc", proc_cnt, 5);
    checkOutput("cnt_byp", byp_cnt, 3);
    force dut.proc_pkt_count_q = 32'hFFFFFFFF;
    #1;
    release dut.proc_pkt_count_q;
    cycle(); applyStimulus(mk(16'h0800, 8'h7F), 32'hFFFFFFFF, 1'b1);
    cycle(); idle();
    @(negedge clk);
    checkOutput("cnt_wrap", proc_cnt, 0);
    checkOutput("cnt_wrap_byp", byp_cnt, 3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
